cfg_sequencer: RTL and testbench
================================

# cfg_sequencer

Configuration sequencer sitting between the Si5340 register ROM and the I2C byte-level master. On a start pulse it walks ROM entries 0..MEM_DEPTH-1. Each 24-bit entry is split into {page, register, data}. It issues a page-select write (register 0x01) only when the page changes, then the register write, as 3-byte I2C transactions on a valid/ready byte stream. After a programmable entry index it inserts the mandatory 300 ms preamble pause.

## Interface
- MEM_DEPTH, 326, number of ROM entries
- MEM_WIDTH, 24, ROM word width; layout {page[23:16], reg[15:8], data[7:0]}
- DATA_WIDTH, 8, byte width toward I2C master
- SLAVE_ADDR, 7'b111_0100, 7-bit I2C device address
- PAUSE_AFTER, 3, pause inserted after this many entries have been sent; 0 disables the pause
- PAUSE_CYCLES, 37_500_000, pause length in clk_i cycles (300 ms at 125 MHz)
- clk_i  in  1  system clock; the block has one clock
- arstn_i  in  1  reset, asynchronous, active-low
- start_i  in  1  single-cycle start pulse; ignored while busy_o=1
- rom_addr_o  out  $clog2(MEM_DEPTH)  ROM read address
- rom_data_i  in  MEM_WIDTH  synchronous ROM data, valid 1 cycle after rom_addr_o
- tx_data_o  out  DATA_WIDTH  byte to I2C master
- tx_valid_o  out  1  byte valid
- tx_ready_i  in  1  I2C master accepts byte
- tx_first_o  out  1  byte is first of a transaction (master issues START)
- tx_last_o  out  1  byte is last of a transaction (master issues STOP after it)
- ack_err_i  in  1  pulse from master: slave NACK on current transaction
- busy_o  out  1  sequence in progress
- done_o  out  1  sticky: all entries written; cleared by next accepted start_i
- error_o  out  1  sticky: sequence aborted on NACK; cleared by next accepted start_i

## Operation
- States: IDLE, FETCH, LOAD, PAGE_TX, REG_TX, PAUSE, FINISH, ERR.
- IDLE/FINISH/ERR + start_i: clear index, done_o, error_o and page_valid; go to FETCH.
- FETCH: rom_addr_o=index; next state LOAD.
- LOAD: register rom_data_i into word. If !page_valid or word.page != cur_page, go to PAGE_TX, else REG_TX.
- PAGE_TX bytes: {SLAVE_ADDR,1'b0}, 8'h01, page. After the last byte is accepted: cur_page<=page, page_valid<=1, go to REG_TX.
- REG_TX bytes: {SLAVE_ADDR,1'b0}, reg, data. After the last byte is accepted, index increments. Next state:
  - PAUSE if index (new value) == PAUSE_AFTER and PAUSE_AFTER != 0;
  - else FINISH if index == MEM_DEPTH;
  - else FETCH.
- PAUSE: counter counts PAUSE_CYCLES cycles, tx_valid_o=0. Then FINISH if index==MEM_DEPTH, else FETCH.
- Byte counter 0..2 within a transaction. tx_first_o=(cnt==0), tx_last_o=(cnt==2), both qualified by tx_valid_o.
- ack_err_i in any TX state: drop tx_valid_o next cycle, set error_o, go to ERR. ack_err_i is ignored in other states.
- FINISH: done_o=1, busy_o=0. ERR: error_o=1, busy_o=0.
- index width $clog2(MEM_DEPTH+1); no wrap, sequence ends at MEM_DEPTH.

## Timing
- Reset values: rom_addr_o=0, tx_data_o=0, tx_valid_o=0, tx_first_o=0, tx_last_o=0, busy_o=0, done_o=0, error_o=0; state IDLE; page_valid=0.
- start_i accepted at edge N: busy_o=1 and FETCH from N+1, LOAD at N+2, first tx_valid_o=1 at N+3.
- Handshake: a byte transfers on a cycle with tx_valid_o&tx_ready_i. tx_data_o, tx_first_o and tx_last_o are held stable while tx_valid_o=1 and tx_ready_i=0.
- Within a transaction the next byte is presented the cycle after the handshake; tx_valid_o stays high. One idle cycle without valid, but not more, may separate PAGE_TX from REG_TX.
- Between entries: 2 cycles with tx_valid_o=0 (FETCH, LOAD).
- Pause: exactly PAUSE_CYCLES cycles with tx_valid_o=0 between the last handshake of entry PAUSE_AFTER-1 and FETCH of entry PAUSE_AFTER.
- Reset asserted mid-sequence: all outputs return to reset values immediately; no partial byte is held.
- start_i together with ack_err_i while busy: ack_err_i wins, start_i is ignored.

## Test plan
- Bench setup: MEM_DEPTH=4, PAUSE_AFTER=2, PAUSE_CYCLES=10, ROM = {00_0B_68, 00_0C_01, 01_02_AA, 01_03_55}, tx_ready_i=1 throughout, start_i pulsed.
  - Expected byte stream: E8 01 00 | E8 0B 68 | E8 0C 01 | E8 01 01 | E8 02 AA | E8 03 55.
  - tx_first_o is set on each E8 byte and tx_last_o on each third byte.
  - done_o=1 at the end; only 2 page writes are issued.
- Pause check: exactly 10 cycles with tx_valid_o=0 between the tx_last_o of entry 1 and FETCH of entry 2; with PAUSE_AFTER=0 there is no gap beyond the 2 fetch cycles.
- Backpressure: hold tx_ready_i=0 for 5 cycles on byte 2 of a transaction; tx_data_o, tx_first_o and tx_last_o stay stable; the stream is unchanged.
- NACK: pulse ack_err_i during the REG_TX of entry 1. Expect tx_valid_o=0 on the next cycle, error_o=1, busy_o=0, and no further ROM fetch. A new start_i clears error_o and restarts at entry 0 with a page write.
- Reset: drop arstn_i during PAUSE. All outputs go to 0 immediately. After release, start_i restarts from entry 0.
- start_i pulsed while busy_o=1: ignored; the stream is identical to the first scenario.

Source files
------------

// File: rtl/cfg_sequencer_if.sv
// Byte stream between the configuration sequencer and the I2C byte-level master.
// The sequencer (master) presents bytes with framing flags. The I2C master
// (slave) accepts them with tx_ready and reports a slave NACK on ack_err.
interface cfg_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_first;
    logic                  tx_last;
    logic                  ack_err;

    modport master (
        output tx_data, tx_valid, tx_first, tx_last,
        input  tx_ready, ack_err
    );

    modport slave (
        input  tx_data, tx_valid, tx_first, tx_last,
        output tx_ready, ack_err
    );
endinterface

// File: rtl/cfg_sequencer.sv
// Si5340 configuration sequencer.
// Walks the register ROM and turns each {page, reg, data} entry into 3-byte
// I2C writes. A page-select write is sent only when the page changes, and a
// single preamble pause is inserted after a programmable number of entries.
module cfg_sequencer #(
    parameter int         MEM_DEPTH    = 326,
    parameter int         MEM_WIDTH    = 24,
    parameter int         DATA_WIDTH   = 8,
    parameter logic [6:0] SLAVE_ADDR   = 7'b111_0100,
    parameter int         PAUSE_AFTER  = 3,
    parameter int         PAUSE_CYCLES = 37_500_000
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic                         start_i,
    output logic [$clog2(MEM_DEPTH)-1:0] rom_addr_o,
    input  logic [MEM_WIDTH-1:0]         rom_data_i,
    cfg_sequencer_if.master              tx,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int IDX_W  = $clog2(MEM_DEPTH + 1);
    localparam int CNT_W  = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_PAGE_TX = 3'd3;
    localparam logic [2:0] S_REG_TX  = 3'd4;
    localparam logic [2:0] S_PAUSE   = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    // Page-select writes target this register of the device.
    localparam logic [7:0] PAGE_REG = 8'h01;

    logic [2:0]           state;
    logic [IDX_W-1:0]     index;
    logic [IDX_W-1:0]     index_inc;
    logic [MEM_WIDTH-1:0] word;
    logic [7:0]           cur_page;
    logic                 page_valid;
    logic [1:0]           byte_cnt;
    logic [CNT_W-1:0]     pause_cnt;
    logic                 in_tx;
    logic                 handshake;
    logic [7:0]           byte_sel;

    assign index_inc = index + IDX_W'(1);
    assign in_tx     = (state == S_PAGE_TX) || (state == S_REG_TX);
    assign handshake = in_tx && tx.tx_ready;

    // Outputs decode straight from state so that an asynchronous reset clears
    // them in the same instant, with no byte left hanging on the bus.
    assign rom_addr_o  = index[ADDR_W-1:0];
    assign tx.tx_valid = in_tx;
    assign tx.tx_first = in_tx && (byte_cnt == 2'd0);
    assign tx.tx_last  = in_tx && (byte_cnt == 2'd2);
    assign tx.tx_data  = in_tx ? DATA_WIDTH'(byte_sel) : '0;
    assign busy_o      = (state != S_IDLE) && (state != S_FINISH) && (state != S_ERR);
    assign done_o      = (state == S_FINISH);
    assign error_o     = (state == S_ERR);

    // Select the byte of the current 3-byte write from the byte counter.
    always_comb begin
        // NOTE: default assignment first so no path leaves byte_sel unassigned (no latch).
        byte_sel = 8'h00;
        case (byte_cnt)
            2'd0:    byte_sel = {SLAVE_ADDR, 1'b0};
            2'd1:    byte_sel = (state == S_PAGE_TX) ? PAGE_REG : word[15:8];
            default: byte_sel = (state == S_PAGE_TX) ? word[23:16] : word[7:0];
        endcase
    end

    // Sequencer FSM with ROM index, page tracking, byte and pause counters.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state      <= S_IDLE;
            index      <= '0;
            word       <= '0;
            cur_page   <= '0;
            page_valid <= 1'b0;
            byte_cnt   <= '0;
            pause_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE, S_FINISH, S_ERR: begin
                    if (start_i) begin
                        index      <= '0;
                        page_valid <= 1'b0;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    word     <= rom_data_i;
                    byte_cnt <= '0;
                    if (!page_valid || (rom_data_i[23:16] != cur_page)) begin
                        state <= S_PAGE_TX;
                    end else begin
                        state <= S_REG_TX;
                    end
                end
                S_PAGE_TX: begin
                    // A NACK outranks a byte accepted in the same cycle.
                    if (tx.ack_err) begin
                        state <= S_ERR;
                    end else if (handshake) begin
                        if (byte_cnt == 2'd2) begin
                            byte_cnt   <= '0;
                            cur_page   <= word[23:16];
                            page_valid <= 1'b1;
                            state      <= S_REG_TX;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                S_REG_TX: begin
                    if (tx.ack_err) begin
                        state <= S_ERR;
                    end else if (handshake) begin
                        if (byte_cnt == 2'd2) begin
                            byte_cnt  <= '0;
                            index     <= index_inc;
                            pause_cnt <= '0;
                            if ((PAUSE_AFTER != 0) && (index_inc == IDX_W'(PAUSE_AFTER))) begin
                                state <= S_PAUSE;
                            end else if (index_inc == IDX_W'(MEM_DEPTH)) begin
                                state <= S_FINISH;
                            end else begin
                                state <= S_FETCH;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                S_PAUSE: begin
                    // Stay exactly PAUSE_CYCLES cycles, then resume or finish.
                    if (pause_cnt == CNT_W'(PAUSE_CYCLES - 1)) begin
                        state <= (index == IDX_W'(MEM_DEPTH)) ? S_FINISH : S_FETCH;
                    end else begin
                        pause_cnt <= pause_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_sequencer.sv
// Bench for cfg_sequencer: a 4-entry ROM, expected bytes queued on start and
// compared as the DUT hands them over, plus a PAUSE_AFTER=0 instance for gaps.
module tb_cfg_sequencer;

    localparam int DEPTH  = 4;
    localparam int NBYTES = 18;

    typedef struct {
        logic [7:0] data;
        logic       first;
        logic       last;
    } exp_byte_t;

    logic clk;
    logic rst_n;
    logic start;
    logic start_np;
    logic [1:0]  rom_addr, rom_addr_np;
    logic [23:0] rom_q, rom_q_np;
    logic busy, done, error;
    logic busy_np, done_np, error_np;

    logic [23:0] rom [DEPTH] = '{24'h000B68, 24'h000C01, 24'h0102AA, 24'h010355};
    logic [7:0]  stream [NBYTES] = '{
        8'hE8, 8'h01, 8'h00,  8'hE8, 8'h0B, 8'h68,  8'hE8, 8'h0C, 8'h01,
        8'hE8, 8'h01, 8'h01,  8'hE8, 8'h02, 8'hAA,  8'hE8, 8'h03, 8'h55};

    cfg_sequencer_if #(.DATA_WIDTH(8)) bus ();
    cfg_sequencer_if #(.DATA_WIDTH(8)) bus_np ();

    cfg_sequencer #(
        .MEM_DEPTH(DEPTH), .MEM_WIDTH(24), .DATA_WIDTH(8), .SLAVE_ADDR(7'b111_0100),
        .PAUSE_AFTER(2), .PAUSE_CYCLES(10)
    ) dut (
        .clk_i(clk), .arstn_i(rst_n), .start_i(start), .rom_addr_o(rom_addr),
        .rom_data_i(rom_q), .tx(bus), .busy_o(busy), .done_o(done), .error_o(error)
    );

    cfg_sequencer #(
        .MEM_DEPTH(DEPTH), .MEM_WIDTH(24), .DATA_WIDTH(8), .SLAVE_ADDR(7'b111_0100),
        .PAUSE_AFTER(0), .PAUSE_CYCLES(10)
    ) dut_np (
        .clk_i(clk), .arstn_i(rst_n), .start_i(start_np), .rom_addr_o(rom_addr_np),
        .rom_data_i(rom_q_np), .tx(bus_np), .busy_o(busy_np), .done_o(done_np),
        .error_o(error_np)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM models: data valid one cycle after the address.
    always @(posedge clk) rom_q    <= rom[rom_addr];
    always @(posedge clk) rom_q_np <= rom[rom_addr_np];

    int n_vec = 0;
    int n_err = 0;

    exp_byte_t sb [$];
    int gaps [$];
    int gaps_np [$];
    int txn_cnt = 0;
    int last_cnt = 0;
    int page_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and transaction counters for the main DUT.
    logic prev_first = 1'b0;
    always @(negedge clk) begin
        if (bus.tx_valid && bus.tx_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                exp_byte_t e;
                e = sb.pop_front();
                check("byte", bus.tx_data, e.data);
                check("first", bus.tx_first, e.first);
                check("last", bus.tx_last, e.last);
            end
            if (bus.tx_first) txn_cnt++;
            if (bus.tx_last) last_cnt++;
            if (prev_first && bus.tx_data == 8'h01) page_cnt++;
            prev_first = bus.tx_first;
        end
    end

    // Count idle cycles between the last byte of one write and the next valid.
    int  gap_len = 0;
    logic gap_on = 1'b0;
    always @(negedge clk) begin
        if (bus.tx_valid) begin
            if (gap_on) gaps.push_back(gap_len);
            gap_on = 1'b0;
            if (bus.tx_ready && bus.tx_last) begin
                gap_on  = 1'b1;
                gap_len = 0;
            end
        end else if (gap_on) begin
            gap_len++;
        end
    end

    int  gap_len_np = 0;
    logic gap_on_np = 1'b0;
    always @(negedge clk) begin
        if (bus_np.tx_valid) begin
            if (gap_on_np) gaps_np.push_back(gap_len_np);
            gap_on_np = 1'b0;
            if (bus_np.tx_ready && bus_np.tx_last) begin
                gap_on_np  = 1'b1;
                gap_len_np = 0;
            end
        end else if (gap_on_np) begin
            gap_len_np++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream();
        for (int i = 0; i < NBYTES; i++) begin
            exp_byte_t e;
            e.data  = stream[i];
            e.first = (i % 3 == 0);
            e.last  = (i % 3 == 2);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Run until done_o, optionally poking start_i while busy; bounded.
    task automatic run_to_done(input int budget, input bit poke);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            start = poke && (i % 5 == 2) && busy;
            tick();
        end
        start = 1'b0;
        check("done", done, 1'b1);
        check("busy_end", busy, 1'b0);
        check("sb_empty", sb.size(), 0);
    endtask

    int base_t, base_l, base_p;
    int k;
    int exp_gap [5]    = '{0, 2, 12, 0, 2};
    int exp_gap_np [5] = '{0, 2, 2, 0, 2};

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        start_np     = 1'b0;
        bus.tx_ready = 1'b1;
        bus.ack_err  = 1'b0;
        bus_np.tx_ready = 1'b1;
        bus_np.ack_err  = 1'b0;
        tick();
        tick();

        // Reset values.
        check("rst_valid", bus.tx_valid, 1'b0);
        check("rst_data", bus.tx_data, 8'h00);
        check("rst_addr", rom_addr, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        rst_n = 1'b1;
        tick();

        // Scenario 1: full sequence, start latency, gaps, page writes.
        base_p = page_cnt;
        push_stream();
        start = 1'b1;
        start_np = 1'b1;
        tick();
        start = 1'b0;
        start_np = 1'b0;
        check("lat_busy", busy, 1'b1);
        check("lat_fetch_valid", bus.tx_valid, 1'b0);
        tick();
        check("lat_load_valid", bus.tx_valid, 1'b0);
        tick();
        check("lat_tx_valid", bus.tx_valid, 1'b1);
        check("lat_tx_first", bus.tx_first, 1'b1);
        check("lat_tx_data", bus.tx_data, 8'hE8);
        run_to_done(200, 1'b0);
        check("page_writes", page_cnt - base_p, 2);
        check("gap_count", gaps.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("gap%0d", i), gaps[i], exp_gap[i]);
        check("np_done", done_np, 1'b1);
        check("np_gap_count", gaps_np.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("np_gap%0d", i), gaps_np[i], exp_gap_np[i]);

        // Scenario 2: backpressure on the middle byte of the first write.
        push_stream();
        pulse_start();
        k = 0;
        while (!(bus.tx_valid && !bus.tx_first && !bus.tx_last) && k < 50) begin
            tick();
            k++;
        end
        check("bp_found", k < 50, 1'b1);
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", bus.tx_valid, 1'b1);
            check("bp_data", bus.tx_data, 8'h01);
            check("bp_first", bus.tx_first, 1'b0);
            check("bp_last", bus.tx_last, 1'b0);
        end
        bus.tx_ready = 1'b1;
        run_to_done(200, 1'b0);

        // Scenario 3: NACK during the register write of entry 1, start ignored.
        push_stream();
        base_t = txn_cnt;
        pulse_start();
        k = 0;
        while (!(txn_cnt - base_t == 2 && bus.tx_valid && bus.tx_first) && k < 100) begin
            tick();
            k++;
        end
        check("nack_found", k < 100, 1'b1);
        bus.ack_err = 1'b1;
        start = 1'b1;
        tick();
        bus.ack_err = 1'b0;
        start = 1'b0;
        check("nack_valid", bus.tx_valid, 1'b0);
        check("nack_error", error, 1'b1);
        check("nack_busy", busy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("nack_idle_valid", bus.tx_valid, 1'b0);
            check("nack_addr", rom_addr, 2'd1);
        end
        sb.delete();
        push_stream();
        pulse_start();
        check("restart_error", error, 1'b0);
        check("restart_busy", busy, 1'b1);
        run_to_done(200, 1'b0);

        // Scenario 4: reset in the middle of the pause.
        push_stream();
        base_l = last_cnt;
        pulse_start();
        k = 0;
        while (!(last_cnt - base_l == 3 && !bus.tx_valid) && k < 100) begin
            tick();
            k++;
        end
        check("pause_found", k < 100, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.tx_valid, 1'b0);
        check("mid_rst_data", bus.tx_data, 8'h00);
        check("mid_rst_first", bus.tx_first, 1'b0);
        check("mid_rst_last", bus.tx_last, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_error", error, 1'b0);
        check("mid_rst_addr", rom_addr, 2'd0);
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
        tick();
        push_stream();
        pulse_start();
        run_to_done(200, 1'b0);

        // Scenario 5: start pulses while busy must not disturb the stream.
        push_stream();
        pulse_start();
        run_to_done(200, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
